// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC frame controller.
package crc_pkg;

    localparam int CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC_SEED = 16'h0000;
    localparam logic [CRC_W-1:0] CRC_GOOD_RESIDUE = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FEED,
        WAIT,
        APPEND,
        REPORT
    } state_t;

endpackage

// File: rtl/crc_wdog.sv
// Watchdog timer that bounds how long the controller waits for the CRC engine.
// The counter holds the number of WAIT cycles already elapsed, so 'expired'
// is high during the TIMEOUT-th cycle of waiting.
module crc_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Elapsed-cycle counter; saturates once expired so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame controller around an external CRC16 engine: passes words through,
// then either appends the CRC (generate) or reports the residue check (check).
//
// state  | meaning
// IDLE   | no frame; waiting for the first upstream word
// CLR    | one-cycle seed pulse to the CRC engine
// FEED   | pass words downstream and into the engine
// WAIT   | waiting for the engine result, bounded by the watchdog
// APPEND | presenting the CRC word downstream (generate mode)
// REPORT | one-cycle check result pulse (check mode)
module crc_frame_ctrl
    import crc_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [CRC_W-1:0] s_data,
    input  logic             s_last,
    input  logic             s_mode,
    output logic             s_ready,
    output logic             m_valid,
    output logic [CRC_W-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             crc_clr,
    output logic             crc_din_valid,
    output logic [CRC_W-1:0] crc_din,
    input  logic             crc_dout_valid,
    input  logic [CRC_W-1:0] crc_dout,
    output logic             chk_done,
    output logic             chk_ok,
    output logic             err_timeout
);

    localparam int WCW = $clog2(MAX_WORDS + 1);

    state_t           state;
    state_t           nxt;
    logic             mode_r;
    logic [CRC_W-1:0] crc_r;
    logic [WCW-1:0]   wcnt;
    logic [WCW-1:0]   cnt_next;
    logic             accept;
    logic             last_acc;
    logic             wd_expired;

    assign accept   = (state == FEED) && s_valid && m_ready;
    assign cnt_next = wcnt + WCW'(1);
    // A full frame ends even when upstream never marks its last word.
    assign last_acc = accept && (s_last || (cnt_next == WCW'(MAX_WORDS)));

    crc_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (last_acc),
        .enable (state == WAIT),
        .expired(wd_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Frame mode, word count and captured engine result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= 1'b0;
            wcnt   <= '0;
            crc_r  <= CRC_SEED;
        end else begin
            if (state == IDLE && s_valid) begin
                mode_r <= s_mode;
            end
            if (state == CLR) begin
                wcnt <= '0;
            end else if (accept) begin
                wcnt <= cnt_next;
            end
            if (state == WAIT && crc_dout_valid) begin
                crc_r <= crc_dout;
            end
        end
    end

    // Next-state and output decode; a valid result beats a same-cycle timeout.
    always_comb begin
        nxt           = state;
        s_ready       = 1'b0;
        m_valid       = 1'b0;
        m_data        = '0;
        m_last        = 1'b0;
        crc_clr       = 1'b0;
        crc_din_valid = 1'b0;
        crc_din       = '0;
        chk_done      = 1'b0;
        chk_ok        = 1'b0;
        err_timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    nxt = CLR;
                end
            end
            CLR: begin
                crc_clr = 1'b1;
                nxt     = FEED;
            end
            FEED: begin
                s_ready       = m_ready;
                m_valid       = s_valid;
                m_data        = s_data;
                m_last        = mode_r & s_last;
                crc_din_valid = accept;
                crc_din       = accept ? s_data : '0;
                if (last_acc) begin
                    nxt = WAIT;
                end
            end
            WAIT: begin
                if (crc_dout_valid) begin
                    nxt = mode_r ? REPORT : APPEND;
                end else if (wd_expired) begin
                    err_timeout = 1'b1;
                    nxt         = IDLE;
                end
            end
            APPEND: begin
                m_valid = 1'b1;
                m_data  = crc_r;
                m_last  = 1'b1;
                if (m_ready) begin
                    nxt = IDLE;
                end
            end
            REPORT: begin
                chk_done = 1'b1;
                chk_ok   = (crc_r == CRC_GOOD_RESIDUE);
                nxt      = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Self-checking bench for crc_frame_ctrl: directed frames plus random frames
// compared against a frame-level model of the expected streams and pulses.
module tb_crc_frame_ctrl;

    localparam int MW = 4;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_mode = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        crc_clr;
    logic        crc_din_valid;
    logic [15:0] crc_din;
    logic        crc_dout_valid = 1'b0;
    logic [15:0] crc_dout = '0;
    logic        chk_done;
    logic        chk_ok;
    logic        err_timeout;

    crc_frame_ctrl #(
        .MAX_WORDS(MW),
        .TIMEOUT  (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_mode        (s_mode),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .crc_clr       (crc_clr),
        .crc_din_valid (crc_din_valid),
        .crc_din       (crc_din),
        .crc_dout_valid(crc_dout_valid),
        .crc_dout      (crc_dout),
        .chk_done      (chk_done),
        .chk_ok        (chk_ok),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [16:0] m_q[$];
    logic [15:0] din_q[$];
    int          clr_n, chk_n, err_n, err_cyc;
    logic        chk_ok_v;
    logic [15:0] fw[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observe all DUT outputs mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (m_valid && m_ready) m_q.push_back({m_last, m_data});
            if (crc_din_valid) din_q.push_back(crc_din);
            if (crc_clr) clr_n++;
            if (chk_done) begin
                chk_n++;
                chk_ok_v = chk_ok;
            end
            if (err_timeout) begin
                err_n++;
                err_cyc = cyc;
            end
        end
    end

    task automatic clear_obs();
        m_q.delete();
        din_q.delete();
        clr_n = 0;
        chk_n = 0;
        err_n = 0;
        err_cyc = -1;
        chk_ok_v = 1'bx;
    endtask

    // Drive one frame from fw, emulate the engine answering 'delay' cycles
    // after the last accepted word (never when delay > TO+3), then compare.
    task automatic run_frame(input bit mode, input bit give_last, input int delay,
                             input logic [15:0] resp, input int ready_pct);
        int n = fw.size();
        int n_acc = (n < MW) ? n : MW;
        bit trunc = (n > MW) || !give_last;
        int i = 0;
        int guard = 0;
        int last_cyc = -1;
        int kmax;
        bit answered;
        logic [16:0] exp_m[$];
        clear_obs();
        // expected streams from the frame-level rules
        for (int j = 0; j < n_acc; j++)
            exp_m.push_back({mode && give_last && (j == n - 1), fw[j]});
        answered = (delay <= TO);
        if (!mode && answered) exp_m.push_back({1'b1, resp});

        while (i < n_acc && guard < 200) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = fw[i];
            s_last  = give_last && (i == n - 1);
            s_mode  = (i == 0) ? mode : 1'($urandom);
            m_ready = ($urandom_range(99) < ready_pct);
            crc_dout_valid = 1'($urandom);
            crc_dout = 16'($urandom);
            #1;
            if (s_valid && s_ready) begin
                i++;
                if (i == n_acc) last_cyc = cyc;
            end
            guard++;
        end
        expect_eq("feed_words", i, n_acc);

        kmax = answered ? delay : TO + 3;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            s_valid = trunc && (k < delay) && (k < TO);
            s_data  = 16'($urandom);
            s_last  = 1'b0;
            m_ready = 1'($urandom);
            crc_dout_valid = (k == delay);
            crc_dout = (k == delay) ? resp : 16'($urandom);
        end

        guard = 0;
        while (m_q.size() < exp_m.size() && guard < 40) begin
            @(negedge clk);
            s_valid = 1'b0;
            crc_dout_valid = 1'b0;
            m_ready = ($urandom_range(99) < 60);
            guard++;
        end
        repeat (3) begin
            @(negedge clk);
            s_valid = 1'b0;
            crc_dout_valid = 1'b0;
            m_ready = 1'b0;
        end

        expect_eq("clr_pulses", clr_n, 1);
        expect_eq("din_count", din_q.size(), n_acc);
        for (int j = 0; j < n_acc && j < din_q.size(); j++)
            expect_eq("din_word", din_q[j], fw[j]);
        expect_eq("m_count", m_q.size(), exp_m.size());
        for (int j = 0; j < exp_m.size() && j < m_q.size(); j++)
            expect_eq("m_word", m_q[j], exp_m[j]);
        expect_eq("chk_pulses", chk_n, (mode && answered) ? 1 : 0);
        if (mode && answered && chk_n == 1)
            expect_eq("chk_ok", chk_ok_v, resp == 16'h0000);
        expect_eq("err_pulses", err_n, answered ? 0 : 1);
        if (!answered && err_n == 1)
            expect_eq("err_cycle", err_cyc, last_cyc + TO);
    endtask

    task automatic check_outputs_zero(input string tag);
        expect_eq({tag, "_flags"},
                  {24'd0, s_ready, m_valid, m_last, crc_clr, crc_din_valid, chk_done, chk_ok, err_timeout},
                  32'd0);
        expect_eq({tag, "_data"}, {m_data, crc_din}, 32'd0);
    endtask

    initial begin
        clear_obs();
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data  = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        s_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // generate, engine answers after 2 cycles
        fw = '{16'h1234, 16'h5678, 16'h9ABC};
        run_frame(1'b0, 1'b1, 2, 16'hBEEF, 100);
        // check mode, good residue, then bad residue
        fw = '{16'h0102, 16'h0304, 16'h0506, 16'hA5C3};
        run_frame(1'b1, 1'b1, 3, 16'h0000, 100);
        fw = '{16'h0102, 16'h0304, 16'h0506, 16'hA5C4};
        run_frame(1'b1, 1'b1, 3, 16'h0001, 70);
        // silent engine, and answer exactly in the last allowed cycle
        fw = '{16'h1111, 16'h2222};
        run_frame(1'b0, 1'b1, 99, 16'h4321, 100);
        fw = '{16'h3333};
        run_frame(1'b0, 1'b1, TO, 16'h4321, 100);
        fw = '{16'h4444, 16'h5555};
        run_frame(1'b1, 1'b1, TO + 1, 16'h0000, 100);
        // MAX_WORDS truncation with toggling downstream ready
        fw = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'hA006};
        run_frame(1'b0, 1'b0, 4, 16'h7E57, 50);

        // reset in the middle of a frame, then a clean frame
        clear_obs();
        begin
            int acc = 0;
            int guard = 0;
            while (acc < 2 && guard < 100) begin
                @(negedge clk);
                s_valid = 1'b1;
                s_data  = 16'hC000 + 16'(acc);
                s_last  = 1'b0;
                s_mode  = 1'b1;
                m_ready = 1'($urandom);
                #1;
                if (s_valid && s_ready) acc++;
                guard++;
            end
            expect_eq("rst_pre_words", acc, 2);
        end
        @(negedge clk);
        s_data = 16'hC002;
        s_last = 1'b1;
        m_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        expect_eq("midrst_no_last", m_q.size() > 0 ? 32'(m_q[m_q.size()-1][16]) : 32'd0, 32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
        rst = 1'b0;
        repeat (TO + 3) @(negedge clk);
        expect_eq("midrst_no_chk", chk_n, 0);
        expect_eq("midrst_no_err", err_n, 0);
        fw = '{16'hD001, 16'hD002, 16'hD003};
        run_frame(1'b0, 1'b1, 5, 16'h1357, 80);

        // random frames
        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(1, 6);
            bit gl = (n <= MW) ? 1'b1 : 1'($urandom);
            int d = $urandom_range(1, TO + 3);
            logic [15:0] r = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
            fw.delete();
            for (int j = 0; j < n; j++) fw.push_back(16'($urandom));
            run_frame(1'($urandom), gl, d, r, $urandom_range(30, 100));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
